// File: rtl/mul_csa_resolve.sv
// Final carry-propagate stage of the multiplier: resolves a redundant (sum, carry)
// pair into a binary product with 4-bit group lookahead, split across two
// valid/ready pipeline stages (low half in stage 1, high half in stage 2).
module mul_csa_resolve #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_hi_sel,
    input  logic [4:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH/2-1:0] out_result,
    output logic [4:0]       out_tag
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NG   = HALF / 4;

    // Group-PG lookahead adder over HALF bits; returns {carry_out, sum}.
    function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] p,
                                              input logic [HALF-1:0] g,
                                              input logic            cin);
        logic [HALF:0] c;
        logic [NG:0]   gc;
        logic          gp;
        logic          gg;
        c     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < int'(NG); k++) begin
            gp = &p[4*k +: 4];
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gc[k+1] = gg | (gp & gc[k]);
            // Ripple inside the group from the lookahead group carry.
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[HALF] = gc[NG];
        return {c[HALF], p ^ c[HALF-1:0]};
    endfunction

    // Stage 1 registers
    logic            s1_valid;
    logic [HALF-1:0] lo_sum;
    logic            c_mid;
    logic [HALF-1:0] hi_p;
    logic [HALF-1:0] hi_g;
    logic            s1_hi_sel;
    logic [4:0]      s1_tag;
    // Stage 2 valid (stage 2 data lives in out_result/out_tag)
    logic            s2_valid;

    logic            s1_valid_d;
    logic            s2_valid_d;
    logic            adv1;
    logic            adv2;
    logic            accept;
    logic [HALF:0]   lo_add;
    logic [HALF:0]   hi_add;

    // Handshake and valid-bit next state; flush dominates everything.
    always_comb begin
        adv2       = !s2_valid || out_ready;
        adv1       = s1_valid && adv2;
        in_ready   = !flush && (!s1_valid || adv2);
        accept     = in_valid && in_ready;
        s1_valid_d = s1_valid;
        s2_valid_d = s2_valid;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (adv1) begin
                s1_valid_d = 1'b0;
            end
            if (adv2) begin
                s2_valid_d = s1_valid;
            end
        end
    end

    // Low half resolved on the way in, high half resolved from registered p/g.
    always_comb begin
        lo_add = cla_add(in_sum[HALF-1:0] ^ in_carry[HALF-1:0],
                         in_sum[HALF-1:0] & in_carry[HALF-1:0], 1'b0);
        hi_add = cla_add(hi_p, hi_g, c_mid);
    end

    // Valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= s1_valid_d;
            s2_valid <= s2_valid_d;
        end
    end

    // Stage 1 capture on accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_sum    <= '0;
            c_mid     <= 1'b0;
            hi_p      <= '0;
            hi_g      <= '0;
            s1_hi_sel <= 1'b0;
            s1_tag    <= '0;
        end else if (accept) begin
            lo_sum    <= lo_add[HALF-1:0];
            c_mid     <= lo_add[HALF];
            hi_p      <= in_sum[WIDTH-1:HALF] ^ in_carry[WIDTH-1:HALF];
            hi_g      <= in_sum[WIDTH-1:HALF] & in_carry[WIDTH-1:HALF];
            s1_hi_sel <= in_hi_sel;
            s1_tag    <= in_tag;
        end
    end

    // Stage 2 capture; holds while stalled so the output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
        end else if (adv1) begin
            out_result <= s1_hi_sel ? hi_add[HALF-1:0] : lo_sum;
            out_tag    <= s1_tag;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_mul_csa_resolve.sv
// Self-checking bench for mul_csa_resolve: directed corner cases plus random
// traffic scored against a queue model using plain 64-bit addition.
module tb_mul_csa_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_sum = '0;
    logic [63:0] in_carry = '0;
    logic        in_hi_sel = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          sent = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    logic        ov_log[12];

    mul_csa_resolve #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_hi_sel  (in_hi_sel),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [63:0] s, input logic [63:0] c,
                                          input logic hi);
        logic [63:0] full;
        full = s + c;
        return hi ? full[63:32] : full[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample at #1 after the falling edge, score transfers, advance to next negedge.
    task automatic tick();
        logic exp_ready;
        exp_t e;
        #1;
        if (prev_stall) begin
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_result", {32'b0, out_result}, {32'b0, prev_res});
            check("hold_tag", {59'b0, out_tag}, {59'b0, prev_tag});
        end
        exp_ready = !flush && (q.size() < 2 || out_ready);
        check("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("out_unexpected", {63'b0, out_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                sent++;
                check("result", {32'b0, out_result}, {32'b0, e.res});
                check("tag", {59'b0, out_tag}, {59'b0, e.tag});
            end
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back('{res: model(in_sum, in_carry, in_hi_sel), tag: in_tag});
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_res   = out_result;
        prev_tag   = out_tag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [63:0] s, input logic [63:0] c, input logic hi,
                         input logic [4:0] t);
        in_valid  = 1'b1;
        in_sum    = s;
        in_carry  = c;
        in_hi_sel = hi;
        in_tag    = t;
    endtask

    // Issue one op into an idle pipeline and check it appears exactly two cycles later.
    task automatic issue_lat(input logic [63:0] s, input logic [63:0] c, input logic hi,
                             input logic [4:0] t, input logic [31:0] exp, input string name);
        out_ready = 1'b1;
        drive(s, c, hi, t);
        tick();
        in_valid = 1'b0;
        check({name, "_n1_valid"}, {63'b0, out_valid}, 64'd0);
        tick();
        check({name, "_n2_valid"}, {63'b0, out_valid}, 64'd1);
        check({name, "_value"}, {32'b0, out_result}, {32'b0, exp});
        tick();
    endtask

    initial begin
        logic [63:0] rs;
        logic [63:0] rc;
        int          n0;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_result", {32'b0, out_result}, 64'd0);
        check("rst_out_tag", {59'b0, out_tag}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {63'b0, in_ready}, 64'd1);

        // Cross-half carry and wrap-around corners.
        issue_lat(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 5'd1, 32'h0, "xhalf_lo");
        issue_lat(64'h00000000_FFFFFFFF, 64'h1, 1'b1, 5'd2, 32'h1, "xhalf_hi");
        issue_lat(64'h80000000_00000000, 64'h80000000_00000000, 1'b1, 5'd3, 32'h0, "wrap_hi");
        issue_lat(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 5'd4, 32'h0, "allones_lo");
        issue_lat(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b1, 5'd5, 32'h0, "allones_hi");
        issue_lat(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b1, 5'd6,
                  32'h22222222, "mixed_hi");

        // Back-to-back: 8 issues, expect 8 consecutive valid cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive({$urandom, $urandom}, {$urandom, $urandom}, i[0], 5'(i));
            else in_valid = 1'b0;
            ov_log[i] = out_valid;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            check($sformatf("b2b_valid_%0d", i), {63'b0, ov_log[i]},
                  (i >= 2 && i < 10) ? 64'd1 : 64'd0);
        end

        // Backpressure: 3 offered while stalled for 5 cycles, only 2 taken.
        out_ready = 1'b0;
        n0 = sent;
        drive(64'h1111, 64'h2222, 1'b0, 5'd10);
        tick();
        drive(64'h3333_0000_0000, 64'h4444_0000_0000, 1'b1, 5'd11);
        tick();
        drive(64'h5555, 64'h6666, 1'b0, 5'd12);
        for (int i = 0; i < 3; i++) tick();
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_delivered", 64'(sent - n0), 64'd3);

        // Flush with both stages full while a new op is offered.
        out_ready = 1'b0;
        drive(64'hAA, 64'hBB, 1'b0, 5'd20);
        tick();
        drive(64'hCC, 64'hDD, 1'b0, 5'd21);
        tick();
        check("fl_full_valid", {63'b0, out_valid}, 64'd1);
        flush = 1'b1;
        drive(64'hEE, 64'hFF, 1'b0, 5'd22);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {63'b0, out_valid}, 64'd0);
        tick();
        check("fl_still_empty", {63'b0, out_valid}, 64'd0);
        issue_lat(64'h7, 64'h9, 1'b0, 5'd23, 32'h10, "post_flush");

        // Reset mid-stream with a full, stalled pipeline.
        out_ready = 1'b0;
        drive(64'hDEAD_BEEF, 64'h1, 1'b0, 5'd24);
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_result", {32'b0, out_result}, 64'd0);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {63'b0, out_valid}, 64'd0);
        issue_lat(64'h1_0000_0003, 64'h2_FFFF_FFFF, 1'b1, 5'd25, 32'h4, "post_rst");

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            rs = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rc = ~rs;
                1: rc = ~rs + 64'(($urandom_range(0, 2)));
                default: rc = {$urandom, $urandom};
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = rs;
            in_carry  = rc;
            in_hi_sel = $urandom_range(0, 1) == 1;
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_valid", {63'b0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
